// File: rtl/wm_pkg.sv
// Shared types and helpers for the washing-machine input frontend.
// State encodings, state width and the credit-width helper live here.
package wm_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'd0
  } wm_state_e;

  function automatic int credit_w(input int coins);
    return $clog2(coins + 1);
  endfunction

endpackage

// File: rtl/wm_input_frontend_if.sv
// Panel, sensor and controller signals seen by the input frontend.
// master = panel/controller side, slave = frontend.
interface wm_input_frontend_if
  import wm_pkg::*;
#(
  parameter int CREDIT_W = 3
);

  logic                lid_raw;
  logic                coin_raw;
  logic                cancel_raw;
  logic [STATE_W-1:0]  state;
  logic                coin_Return;
  logic                sig_Lid_Closed;
  logic                sig_Coin;
  logic                sig_Cancel;
  logic                sig_Time_Out;
  logic [CREDIT_W-1:0] credit;

  modport master (
    output lid_raw,
    output coin_raw,
    output cancel_raw,
    output state,
    output coin_Return,
    input  sig_Lid_Closed,
    input  sig_Coin,
    input  sig_Cancel,
    input  sig_Time_Out,
    input  credit
  );

  modport slave (
    input  lid_raw,
    input  coin_raw,
    input  cancel_raw,
    input  state,
    input  coin_Return,
    output sig_Lid_Closed,
    output sig_Coin,
    output sig_Cancel,
    output sig_Time_Out,
    output credit
  );

endinterface

// File: rtl/wm_debounce.sv
// Two-flop synchroniser followed by a stable-count filter.
// The level follows the input only after CYCLES consecutive differing samples.
module wm_debounce #(
  parameter int CYCLES = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic level
);

  localparam int CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      // any sample agreeing with the output restarts the run
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/wm_input_frontend.sv
// Lid debounce, coin credit, cancel edge and per-state watchdog.
// Define WM_TIMEOUT_EN to build the watchdog; otherwise sig_Time_Out is 0.
module wm_input_frontend
  import wm_pkg::*;
#(
  parameter int                 DEBOUNCE_CYCLES = 16,
  parameter int                 COINS_REQUIRED  = 4,
  parameter int                 TIMEOUT_CYCLES  = 1000,
  parameter logic [STATE_W-1:0] IDLE_STATE      = ST_IDLE
) (
  input logic                clock,
  input logic                reset_n,
  wm_input_frontend_if.slave bus
);

  localparam int CREDIT_W = credit_w(COINS_REQUIRED);
  localparam logic [CREDIT_W-1:0] CREDIT_LAST =
    CREDIT_W'(COINS_REQUIRED - 1);

  logic                lid_q;
  logic [1:0]          s1;
  logic [1:0]          s2;
  logic [1:0]          sd;
  logic [1:0]          rise;
  logic                coin_q;
  logic                cancel_q;
  logic [CREDIT_W-1:0] credit_q;

  wm_debounce #(
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_lid (
    .clock   (clock),
    .reset_n (reset_n),
    .raw     (bus.lid_raw),
    .level   (lid_q)
  );

  assign rise = s2 & ~sd;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1       <= '0;
      s2       <= '0;
      sd       <= '0;
      coin_q   <= 1'b0;
      cancel_q <= 1'b0;
      credit_q <= '0;
    end else begin
      s1       <= {bus.cancel_raw, bus.coin_raw};
      s2       <= s1;
      sd       <= s2;
      cancel_q <= rise[1];
      coin_q   <= 1'b0;
      // refund beats a coinciding coin
      if (bus.coin_Return) begin
        credit_q <= '0;
      end else if (rise[0] && bus.state == IDLE_STATE) begin
        if (credit_q == CREDIT_LAST) begin
          credit_q <= '0;
          coin_q   <= 1'b1;
        end else begin
          credit_q <= credit_q + 1'b1;
        end
      end
    end
  end

`ifdef WM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

  logic [STATE_W-1:0] state_d;
  logic [TW-1:0]      tmo_cnt;
  logic               tmo_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_d <= '0;
      tmo_cnt <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_d <= bus.state;
      tmo_q   <= 1'b0;
      if (bus.state != state_d || bus.state == IDLE_STATE) begin
        tmo_cnt <= '0;
      end else if (tmo_cnt != TMO_MAX) begin
        tmo_cnt <= tmo_cnt + 1'b1;
        tmo_q   <= (tmo_cnt == TMO_MAX - 1'b1);
      end
    end
  end

  assign bus.sig_Time_Out = tmo_q;
`else
  localparam int unused_tmo_cycles = TIMEOUT_CYCLES;
  assign bus.sig_Time_Out = 1'b0;
`endif

  assign bus.sig_Lid_Closed = lid_q;
  assign bus.sig_Coin       = coin_q;
  assign bus.sig_Cancel     = cancel_q;
  assign bus.credit         = credit_q;

endmodule

// File: tb/tb_wm_input_frontend.sv
// Self-checking bench for wm_input_frontend.
// Small parameters; watchdog expectations follow WM_TIMEOUT_EN.
module tb_wm_input_frontend;

`ifdef WM_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  wm_input_frontend_if #(.CREDIT_W(2)) bus ();

  wm_input_frontend #(
    .DEBOUNCE_CYCLES (4),
    .COINS_REQUIRED  (3),
    .TIMEOUT_CYCLES  (10),
    .IDLE_STATE      (3'd0)
  ) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic       coin;
    logic [1:0] credit;
  } exp_t;

  typedef struct {
    logic [2:0] st;
    logic       ret;
    logic       exp_coin;
    logic [1:0] exp_credit;
  } coin_vec_t;

  exp_t      sb[$];
  coin_vec_t vecs[10];
  int        n_checks = 0;
  int        n_pass = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // One coin pulse, 3 clocks wide; credit lands on the 3rd edge.
  task automatic coin_step(input logic [2:0] st, input logic ret,
                           input logic ec, input logic [1:0] ecr);
    exp_t e;
    sb.push_back('{coin: ec, credit: ecr});
    bus.state    = st;
    bus.coin_raw = 1'b1;
    tick();
    tick();
    bus.coin_Return = ret;
    tick();
    bus.coin_Return = 1'b0;
    bus.coin_raw    = 1'b0;
    e = sb.pop_front();
    check("sig_coin", 32'(bus.sig_Coin), 32'(e.coin));
    check("credit", 32'(bus.credit), 32'(e.credit));
    tick();
    check("sig_coin_width", 32'(bus.sig_Coin), 32'd0);
    tick();
    tick();
  endtask

  task automatic run_state(input logic [2:0] a, input int na,
                           input logic [2:0] b, input int total,
                           output int npulse, output int first);
    npulse = 0;
    first  = 0;
    for (int i = 1; i <= total; i++) begin
      bus.state = (i <= na) ? a : b;
      tick();
      if (bus.sig_Time_Out) begin
        npulse++;
        if (first == 0) first = i;
      end
    end
  endtask

  initial begin
    int first;
    int npulse;
    logic min_lid;

    vecs[0] = '{3'd0, 1'b0, 1'b0, 2'd1};
    vecs[1] = '{3'd0, 1'b0, 1'b0, 2'd2};
    vecs[2] = '{3'd0, 1'b0, 1'b1, 2'd0};
    vecs[3] = '{3'd3, 1'b0, 1'b0, 2'd0};
    vecs[4] = '{3'd0, 1'b0, 1'b0, 2'd1};
    vecs[5] = '{3'd3, 1'b0, 1'b0, 2'd1};
    vecs[6] = '{3'd0, 1'b1, 1'b0, 2'd0};
    vecs[7] = '{3'd0, 1'b0, 1'b0, 2'd1};
    vecs[8] = '{3'd0, 1'b0, 1'b0, 2'd2};
    vecs[9] = '{3'd0, 1'b0, 1'b1, 2'd0};

    bus.lid_raw     = 1'b0;
    bus.coin_raw    = 1'b0;
    bus.cancel_raw  = 1'b0;
    bus.state       = 3'd0;
    bus.coin_Return = 1'b0;
    tick();
    tick();
    check("rst_lid", 32'(bus.sig_Lid_Closed), 32'd0);
    check("rst_credit", 32'(bus.credit), 32'd0);
    check("rst_pulses", 32'({bus.sig_Coin, bus.sig_Cancel,
                             bus.sig_Time_Out}), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();

    // lid bounce 1,0,1 then stable: 4 counts after 2-flop sync
    first = 0;
    for (int i = 1; i <= 12; i++) begin
      bus.lid_raw = (i == 2) ? 1'b0 : 1'b1;
      tick();
      if (bus.sig_Lid_Closed && first == 0) first = i;
    end
    check("lid_rise_cycle", 32'(first), 32'd8);
    check("lid_level", 32'(bus.sig_Lid_Closed), 32'd1);

    // 3-cycle dropout is shorter than the filter
    min_lid = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      bus.lid_raw = (i <= 3) ? 1'b0 : 1'b1;
      tick();
      min_lid = min_lid & bus.sig_Lid_Closed;
    end
    check("lid_glitch", 32'(min_lid), 32'd1);

    npulse = 0;
    first  = 0;
    for (int i = 1; i <= 20; i++) begin
      bus.cancel_raw = 1'b1;
      tick();
      if (bus.sig_Cancel) begin
        npulse++;
        if (first == 0) first = i;
      end
    end
    bus.cancel_raw = 1'b0;
    tick();
    tick();
    tick();
    check("cancel_count", 32'(npulse), 32'd1);
    check("cancel_latency", 32'(first), 32'd3);

    for (int i = 0; i < 10; i++)
      coin_step(vecs[i].st, vecs[i].ret,
                vecs[i].exp_coin, vecs[i].exp_credit);
    bus.state = 3'd0;
    tick();
    tick();

    run_state(3'd2, 15, 3'd2, 15, npulse, first);
    check("tmo_count", 32'(npulse), 32'(TMO_ON));
    check("tmo_cycle", 32'(first), TMO_ON ? 32'd11 : 32'd0);
    run_state(3'd0, 3, 3'd0, 3, npulse, first);

    // change on the cycle that would have expired
    run_state(3'd2, 10, 3'd4, 22, npulse, first);
    check("tmo_restart_count", 32'(npulse), 32'(TMO_ON));
    check("tmo_restart_cycle", 32'(first), TMO_ON ? 32'd21 : 32'd0);
    run_state(3'd0, 3, 3'd0, 3, npulse, first);

    run_state(3'd2, 50, 3'd2, 50, npulse, first);
    check("tmo_hold50", 32'(npulse), 32'(TMO_ON));
    run_state(3'd0, 3, 3'd0, 3, npulse, first);

    // async reset mid-count with credit 2 and lid closed
    coin_step(3'd0, 1'b0, 1'b0, 2'd1);
    coin_step(3'd0, 1'b0, 1'b0, 2'd2);
    bus.coin_raw = 1'b1;
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_credit", 32'(bus.credit), 32'd0);
    check("async_rst_lid", 32'(bus.sig_Lid_Closed), 32'd0);
    check("async_rst_coin", 32'(bus.sig_Coin), 32'd0);
    bus.coin_raw = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    check("post_rst_credit", 32'(bus.credit), 32'd0);
    check("post_rst_lid", 32'(bus.sig_Lid_Closed), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
